// File: rtl/uart_flag_pkg.sv
// Shared definitions for the UART flag server.
//   state_t   : state encoding exported on state_out (3 = NAK, reserved even
//               when the NAK response is compiled out)
//   NAK_BYTE  : byte sent back for a wrong attempt ('!')
//   byte_sel  : picks byte i (0 = most significant) out of a packed vector
package uart_flag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_NAK    = 2'd3
  } state_t;

  localparam logic [7:0] NAK_BYTE = 8'h21;

  // Widest vector / byte the selector handles; callers zero-extend into it
  // and truncate the result back to their own byte width.
  localparam int unsigned SEL_VEC_W  = 1024;
  localparam int unsigned SEL_BYTE_W = 32;

  function automatic logic [SEL_BYTE_W-1:0] byte_sel(
    input logic [SEL_VEC_W-1:0] vec,
    input int unsigned          len,
    input int unsigned          dbits,
    input int unsigned          i
  );
    logic [SEL_VEC_W-1:0] sh;
    sh = vec >> ((len - 1 - i) * dbits);
    return sh[SEL_BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_flag_server_if.sv
// Byte-stream bundle between the UART core and the flag server.
//   rx_data/rx_valid : received byte, one-cycle strobe (core -> server)
//   tx_data/tx_valid : byte to transmit (server -> core)
//   tx_ready         : core accepts the byte when tx_valid && tx_ready
// master = UART core side, slave = flag server side.
interface uart_flag_server_if #(
  parameter int unsigned DBITS = 8
);
  logic [DBITS-1:0] rx_data;
  logic             rx_valid;
  logic [DBITS-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/uart_byte_serializer.sv
// Streams a packed LEN*DBITS vector out MSB byte first over valid/ready.
//   clk, reset_n : clock, synchronous active-low reset
//   data         : vector to send (must stay stable while busy)
//   start        : one-cycle pulse; tx_valid rises the following cycle
//   tx_ready     : downstream accept
//   tx_valid     : byte on tx_data is valid
//   tx_data      : current byte, 0 while idle
//   done         : one-cycle pulse on the handshake of the last byte
module uart_byte_serializer
  import uart_flag_pkg::*;
#(
  parameter int unsigned DBITS = 8,
  parameter int unsigned LEN   = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LEN*DBITS-1:0] data,
  input  logic                 start,
  input  logic                 tx_ready,
  output logic                 tx_valid,
  output logic [DBITS-1:0]     tx_data,
  output logic                 done
);
  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;

  logic          busy;
  logic [IW-1:0] idx;
  logic          last;

  assign last = (idx == IW'(LEN - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy && tx_ready) begin
      if (last) begin
        busy <= 1'b0;
        idx  <= '0;
      end else begin
        idx  <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx_valid = busy;
    tx_data  = '0;
    if (busy)
      tx_data = DBITS'(byte_sel(SEL_VEC_W'(data), LEN, DBITS, 32'(idx)));
    done = busy && tx_ready && last;
  end

endmodule

// File: rtl/uart_flag_server.sv
// Key-gated flag server between a UART core's RX and TX byte streams.
// Collects KEY_LEN bytes per attempt; a match streams FLAG out, a miss bumps
// fail_cnt, and MAX_TRIES misses lock the block for LOCKOUT_CYCLES cycles.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : rx/tx byte streams (slave side)
//   state_out    : 0 IDLE, 1 SEND, 2 LOCKED, 3 NAK
//   fail_cnt     : wrong attempts since the last clear
//   flag_sent    : pulse on acceptance of the last flag byte
//   dropped      : pulse when an rx byte arrives outside IDLE
// Build option: define UART_FLAG_NAK_EN to answer a non-locking wrong
// attempt with a single NAK_BYTE; otherwise the miss is silent.
module uart_flag_server
  import uart_flag_pkg::*;
#(
  parameter int unsigned              DBITS          = 8,
  parameter int unsigned              FLAG_LEN       = 18,
  parameter logic [FLAG_LEN*DBITS-1:0] FLAG          = 144'h7b68695f69276d5f796f75725f61726d797d,
  parameter int unsigned              KEY_LEN        = 4,
  parameter logic [KEY_LEN*DBITS-1:0] KEY            = 32'h67623235,
  parameter int unsigned              MAX_TRIES      = 3,
  parameter int unsigned              LOCKOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  uart_flag_server_if.slave              bus,
  output logic [1:0]                     state_out,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic                           flag_sent,
  output logic                           dropped
);
  localparam int unsigned IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned FW = $clog2(MAX_TRIES + 1);
  localparam int unsigned KW = KEY_LEN * DBITS;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [KW-1:0] shreg, shreg_nx, shifted;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic [FW-1:0] fails_nx;

  logic             ser_start, ser_valid, ser_done;
  logic [DBITS-1:0] ser_data;

  uart_byte_serializer #(
    .DBITS (DBITS),
    .LEN   (FLAG_LEN)
  ) u_ser (
    .clk      (clk),
    .reset_n  (reset_n),
    .data     (FLAG),
    .start    (ser_start),
    .tx_ready (bus.tx_ready),
    .tx_valid (ser_valid),
    .tx_data  (ser_data),
    .done     (ser_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      shreg    <= '0;
      lock_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      shreg    <= shreg_nx;
      lock_cnt <= lock_nx;
      fail_cnt <= fails_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    shreg_nx  = shreg;
    lock_nx   = lock_cnt;
    fails_nx  = fail_cnt;
    ser_start = 1'b0;
    // Compare sees the register including the byte arriving this cycle.
    shifted   = (shreg << DBITS) | KW'(bus.rx_data);

    case (state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          shreg_nx = shifted;
          if (idx == IW'(KEY_LEN - 1)) begin
            idx_nx = '0;
            if (shifted == KEY) begin
              state_nx  = ST_SEND;
              fails_nx  = '0;
              ser_start = 1'b1;
            end else begin
              fails_nx = fail_cnt + 1'b1;
              if (fails_nx == FW'(MAX_TRIES)) begin
                state_nx = ST_LOCKED;
                lock_nx  = LW'(LOCKOUT_CYCLES - 1);
              end else begin
`ifdef UART_FLAG_NAK_EN
                state_nx = ST_NAK;
`else
                state_nx = ST_IDLE;
`endif
              end
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (ser_done) state_nx = ST_IDLE;
      end
      ST_LOCKED: begin
        if (lock_cnt == '0) begin
          state_nx = ST_IDLE;
          fails_nx = '0;
        end else begin
          lock_nx = lock_cnt - 1'b1;
        end
      end
      ST_NAK: begin
        if (bus.tx_ready) state_nx = ST_IDLE;
      end
    endcase
  end

  // NAK borrows the tx port around the serializer, which is idle then.
  always_comb begin
    bus.tx_valid = ser_valid;
    bus.tx_data  = ser_data;
    if (state == ST_NAK) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = DBITS'(NAK_BYTE);
    end
    flag_sent = reset_n && ser_done;
    dropped   = reset_n && bus.rx_valid && (state != ST_IDLE);
    state_out = state;
  end

endmodule
